sampled_edge_monitor: RTL and testbench
=======================================

// Module: sampled_edge_monitor
// PURPOSE
//  Synthesizable RTL counterpart of the $rose/$fell/$stable/$changed sampled-value functions.
//  Samples a WIDTH-bit input on posedge clk and produces registered per-bit rise and fall pulses.
//  Also produces aggregate changed/stable flags, saturating event counters and a stable-run
//  length, plus a sticky min-pulse-width violation flag.
//  Sits between an asynchronous or peer-clocked signal source and status/interrupt logic.
// PARAMETERS
//  WIDTH       1   number of monitored bits (1..32)
//  SYNC_STAGES 2   input synchronizer flops (0 = input already synchronous, else 2 or 3)
//  CNT_W       8   width of rise_cnt, fall_cnt and run_len (saturating)
//  MIN_STABLE  2   minimum cycles the sampled value must hold between changes (>=1)
// PORTS
//  clk       in   1      clock, all logic on posedge
//  rst_n     in   1      asynchronous active-low reset
//  en_i      in   1      monitor enable
//  clr_i     in   1      synchronous clear of counters and sticky flag (single-cycle pulse)
//  sig_in    in   WIDTH  monitored signal
//  rose_o    out  WIDTH  per-bit rise pulse, one cycle wide
//  fell_o    out  WIDTH  per-bit fall pulse, one cycle wide
//  changed_o out  1      |(rose_o|fell_o)
//  stable_o  out  1      ~changed_o while en_i is high, else 0
//  rise_cnt  out  CNT_W  cycles with any rise since reset/clear, saturates at all-ones
//  fall_cnt  out  CNT_W  cycles with any fall since reset/clear, saturates at all-ones
//  run_len   out  CNT_W  consecutive cycles without change, saturating
//  viol_o    out  1      sticky: change seen while run_len < MIN_STABLE-1
// BEHAVIOUR
//  Reset: all flops, including synchronizers, are cleared; s_q and p_q become 0.
//   Every output reads 0.
//  Pipeline: sync chain -> s_q (sample n) -> p_q (sample n-1).
//   rose_o <= en_i & s_q & ~p_q
//   fell_o <= en_i & ~s_q & p_q
//  Latency (SYNC_STAGES=0): sig_in changes before edge k, so s_q updates at edge k.
//   rose_o/fell_o are high for exactly one cycle after edge k+1.
//   Each synchronizer stage adds 1 cycle.
//  Reset value of p_q is 0, so a 1 present at the first sample after reset gives a rose pulse.
//   This matches $rose on a 2-state bit.
//  en_i=0:
//   - s_q and p_q keep updating, so no stale edge appears on re-enable.
//   - rose_o, fell_o and changed_o are forced to 0; stable_o is 0.
//   - counters, run_len and viol_o hold.
//  Counters update one cycle after the corresponding pulse, registered from rose_o/fell_o:
//   - rise_cnt += 1 if |rose_o; fall_cnt += 1 if |fell_o.
//   - A cycle with both (different bits) increments both.
//   - Each counter holds at 2^CNT_W-1 and never wraps.
//  run_len: cleared to 0 on changed_o, else increments (saturating) while en_i is high.
//  viol_o: set when changed_o=1 and run_len < MIN_STABLE-1. Stays set until clr_i or reset.
//  clr_i: zeroes rise_cnt, fall_cnt, run_len and viol_o at the next edge.
//   If clr_i coincides with a counted event, the result is the post-clear count
//   (counter = 1, or viol_o = 1 if the violation condition holds that cycle).
//  Reset mid-operation aborts in-flight pulses; no pulse is emitted for pre-reset edges.
//  Per-bit rise and fall can never be high together for the same bit.
// CONFIGURATION
//  SAMPLED_EDGE_MON_SVA_EN defined: concurrent assertions are compiled in, clocked on posedge clk
//  and disabled while !rst_n:
//   - rose_o == $past(en_i & $rose(s_q))
//   - fell_o == $past(en_i & $fell(s_q))
//   - stable_o |-> $past($stable(s_q))
//   - $onehot0 per bit of {rose_o[i], fell_o[i]}
//  Any assertion failure calls $error.
//  Not defined: pure synthesizable RTL, no assertion code present. Functional behaviour is identical.
// TESTING  (clk period 10, WIDTH=1, SYNC_STAGES=0, MIN_STABLE=2, CNT_W=8)
//  Reset release, sig_in=0 -> all outputs 0; run_len counts 1,2,3... while en_i=1.
//  sig_in 0->1 before edge k, held -> rose_o=1 only after edge k+1; rise_cnt=1 at k+2;
//   run_len cleared at k+2.
//  Drive 0,1(10),0(20),1(10),0(13),1(10),0(7),1(10) -> rise_cnt=4 and fall_cnt=3;
//   viol_o=1 after the 1-cycle pulse.
//  Glitch: 2ns high pulse between edges -> no rose_o/fell_o, counters unchanged.
//  en_i=0 across a rise, then en_i=1 -> no rose_o at any point; rise_cnt unchanged.
//  Force 260 rises -> rise_cnt holds 255; clr_i coincident with a rise -> rise_cnt=1.
//  Async rst_n low mid-pulse -> rose_o drops immediately; counters read 0.

Source files
------------

// File: rtl/sampled_edge_monitor.sv
// sampled_edge_monitor: registered $rose/$fell/$stable/$changed equivalents on a
// synchronized WIDTH-bit input, with saturating event counters, stable-run length
// and a sticky minimum-pulse-width violation flag.
// Optional macro SAMPLED_EDGE_MON_SVA_EN compiles in concurrent assertions.
module sampled_edge_monitor #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned MIN_STABLE  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] sig_in,
  output logic [WIDTH-1:0] rose_o,
  output logic [WIDTH-1:0] fell_o,
  output logic             changed_o,
  output logic             stable_o,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic [CNT_W-1:0] run_len,
  output logic             viol_o
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] VIOL_THRS = CNT_W'(MIN_STABLE - 1);

  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] rose_d;
  logic [WIDTH-1:0] fell_d;
  logic             any_change_c;
  logic             viol_cond_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_out = sig_in;
    end else begin : g_sync
      logic [WIDTH-1:0] sync_q [SYNC_STAGES];

      // Metastability synchronizer chain
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= sig_in;
          for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
      end

      assign sync_out = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Edge detection on current vs previous sample, gated by enable
  always_comb begin
    rose_d       = '0;
    fell_d       = '0;
    any_change_c = 1'b0;
    if (en_i) begin
      rose_d       = s_q & ~p_q;
      fell_d       = ~s_q & p_q;
      any_change_c = |(s_q ^ p_q);
    end
    viol_cond_c = changed_o && (run_len < VIOL_THRS);
  end

  // Sample pipeline and registered pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q       <= '0;
      p_q       <= '0;
      rose_o    <= '0;
      fell_o    <= '0;
      changed_o <= 1'b0;
      stable_o  <= 1'b0;
    end else begin
      s_q       <= sync_out;
      p_q       <= s_q;
      rose_o    <= rose_d;
      fell_o    <= fell_d;
      changed_o <= any_change_c;
      stable_o  <= en_i & ~any_change_c;
    end
  end

  // Saturating event counters, counted one cycle after the pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_cnt <= '0;
      fall_cnt <= '0;
    end else if (clr_i) begin
      rise_cnt <= CNT_W'(|rose_o);
      fall_cnt <= CNT_W'(|fell_o);
    end else begin
      if (|rose_o) rise_cnt <= sat_inc(rise_cnt);
      if (|fell_o) fall_cnt <= sat_inc(fall_cnt);
    end
  end

  // Stable-run length and sticky min-width violation flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_len <= '0;
      viol_o  <= 1'b0;
    end else if (clr_i) begin
      run_len <= '0;
      viol_o  <= viol_cond_c;
    end else begin
      if (changed_o)  run_len <= '0;
      else if (en_i)  run_len <= sat_inc(run_len);
      if (viol_cond_c) viol_o <= 1'b1;
    end
  end

`ifdef SAMPLED_EDGE_MON_SVA_EN
  generate
    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_sva
      // Rise pulse mirrors $rose of the sample one cycle earlier
      a_rose : assert property (@(posedge clk) disable iff (!rst_n)
        rose_o[gi] == $past(en_i & $rose(s_q[gi])))
        else $error("rose_o[%0d] disagrees with $rose", gi);
      // Fall pulse mirrors $fell of the sample one cycle earlier
      a_fell : assert property (@(posedge clk) disable iff (!rst_n)
        fell_o[gi] == $past(en_i & $fell(s_q[gi])))
        else $error("fell_o[%0d] disagrees with $fell", gi);
      // Rise and fall never coincide on one bit
      a_excl : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({rose_o[gi], fell_o[gi]}))
        else $error("rose_o/fell_o both high on bit %0d", gi);
    end
  endgenerate

  // Stable flag implies the sample did not change
  a_stable : assert property (@(posedge clk) disable iff (!rst_n)
    stable_o |-> $past($stable(s_q)))
    else $error("stable_o high while sample changed");
`endif

endmodule

// File: tb/tb_sampled_edge_monitor.sv
// Directed self-checking bench for sampled_edge_monitor (WIDTH=1, SYNC_STAGES=0).
module tb_sampled_edge_monitor;

  localparam int unsigned WIDTH = 1;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             en_i;
  logic             clr_i;
  logic [WIDTH-1:0] sig_in;
  logic [WIDTH-1:0] rose_o;
  logic [WIDTH-1:0] fell_o;
  logic             changed_o;
  logic             stable_o;
  logic [CNT_W-1:0] rise_cnt;
  logic [CNT_W-1:0] fall_cnt;
  logic [CNT_W-1:0] run_len;
  logic             viol_o;

  int vectors = 0;
  int errors  = 0;

  sampled_edge_monitor #(
    .WIDTH(WIDTH), .SYNC_STAGES(0), .CNT_W(CNT_W), .MIN_STABLE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .clr_i(clr_i), .sig_in(sig_in),
    .rose_o(rose_o), .fell_o(fell_o), .changed_o(changed_o), .stable_o(stable_o),
    .rise_cnt(rise_cnt), .fall_cnt(fall_cnt), .run_len(run_len), .viol_o(viol_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_clear();
    @(negedge clk) clr_i = 1'b1;
    @(negedge clk) clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_i = 1'b1; clr_i = 1'b0; sig_in = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({rose_o, fell_o, changed_o, stable_o, rise_cnt, fall_cnt, run_len, viol_o} !== '0) begin
      $display("FAIL reset_outputs: got rose=%b fell=%b chg=%b stb=%b rc=%0d fc=%0d rl=%0d v=%b, expected all 0",
               rose_o, fell_o, changed_o, stable_o, rise_cnt, fall_cnt, run_len, viol_o);
      errors++;
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      vectors++;
      if (run_len !== CNT_W'(i) || stable_o !== 1'b1) begin
        $display("FAIL reset_run_len: got run_len=%0d stable=%b, expected %0d/1", run_len, stable_o, i);
        errors++;
      end
    end
  endtask

  task automatic test_single_rise();
    logic [CNT_W-1:0] rc0;
    rc0 = rise_cnt;
    @(negedge clk) sig_in = 1'b1;     // before edge k
    @(negedge clk);                   // after edge k
    vectors++;
    if (rose_o !== 1'b0) begin
      $display("FAIL rise_early: got rose=%b, expected 0", rose_o);
      errors++;
    end
    @(negedge clk);                   // after edge k+1
    vectors++;
    if (rose_o !== 1'b1 || fell_o !== 1'b0 || changed_o !== 1'b1 || stable_o !== 1'b0 || rise_cnt !== rc0) begin
      $display("FAIL rise_pulse: got rose=%b fell=%b chg=%b stb=%b rc=%0d, expected 1/0/1/0/%0d",
               rose_o, fell_o, changed_o, stable_o, rise_cnt, rc0);
      errors++;
    end
    @(negedge clk);                   // after edge k+2
    vectors++;
    if (rose_o !== 1'b0 || rise_cnt !== rc0 + CNT_W'(1) || run_len !== '0) begin
      $display("FAIL rise_after: got rose=%b rc=%0d rl=%0d, expected 0/%0d/0",
               rose_o, rise_cnt, run_len, rc0 + CNT_W'(1));
      errors++;
    end
  endtask

  task automatic test_pattern();
    @(negedge clk) sig_in = 1'b0;
    repeat (5) @(negedge clk);
    pulse_clear();
    vectors++;
    if (rise_cnt !== '0 || fall_cnt !== '0 || viol_o !== 1'b0) begin
      $display("FAIL pattern_clear: got rc=%0d fc=%0d v=%b, expected 0/0/0", rise_cnt, fall_cnt, viol_o);
      errors++;
    end
    sig_in = 1'b1; #10; sig_in = 1'b0; #20; sig_in = 1'b1; #10;
    sig_in = 1'b0; #13; sig_in = 1'b1; #10; sig_in = 1'b0; #7; sig_in = 1'b1;
    repeat (6) @(negedge clk);
    vectors++;
    if (rise_cnt !== CNT_W'(4) || fall_cnt !== CNT_W'(3) || viol_o !== 1'b1) begin
      $display("FAIL pattern_counts: got rc=%0d fc=%0d v=%b, expected 4/3/1", rise_cnt, fall_cnt, viol_o);
      errors++;
    end
  endtask

  task automatic test_glitch();
    logic [CNT_W-1:0] rc0, fc0;
    @(negedge clk) sig_in = 1'b0;
    repeat (5) @(negedge clk);
    rc0 = rise_cnt; fc0 = fall_cnt;
    sig_in = 1'b1; #2; sig_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (rose_o !== 1'b0 || fell_o !== 1'b0) begin
        $display("FAIL glitch_pulse: got rose=%b fell=%b, expected 0/0", rose_o, fell_o);
        errors++;
      end
    end
    vectors++;
    if (rise_cnt !== rc0 || fall_cnt !== fc0) begin
      $display("FAIL glitch_counts: got rc=%0d fc=%0d, expected %0d/%0d", rise_cnt, fall_cnt, rc0, fc0);
      errors++;
    end
  endtask

  task automatic test_enable();
    logic [CNT_W-1:0] rc0, rl0;
    @(negedge clk) en_i = 1'b0;
    rc0 = rise_cnt; rl0 = run_len;
    @(negedge clk) sig_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (rose_o !== 1'b0 || stable_o !== 1'b0 || changed_o !== 1'b0) begin
        $display("FAIL disabled_out: got rose=%b stb=%b chg=%b, expected 0/0/0", rose_o, stable_o, changed_o);
        errors++;
      end
    end
    vectors++;
    if (run_len !== rl0) begin
      $display("FAIL disabled_run_len: got %0d, expected %0d", run_len, rl0);
      errors++;
    end
    en_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (rose_o !== 1'b0) begin
        $display("FAIL reenable_rose: got %b, expected 0", rose_o);
        errors++;
      end
    end
    vectors++;
    if (rise_cnt !== rc0) begin
      $display("FAIL reenable_cnt: got %0d, expected %0d", rise_cnt, rc0);
      errors++;
    end
  endtask

  task automatic test_saturation();
    @(negedge clk) sig_in = 1'b0;
    repeat (3) @(negedge clk);
    pulse_clear();
    for (int i = 0; i < 260; i++) begin
      sig_in = 1'b1;
      @(negedge clk) sig_in = 1'b0;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (rise_cnt !== 8'd255 || fall_cnt !== 8'd255) begin
      $display("FAIL saturate: got rc=%0d fc=%0d, expected 255/255", rise_cnt, fall_cnt);
      errors++;
    end
    sig_in = 1'b1;                    // before edge k
    @(negedge clk);                   // after k
    @(negedge clk) clr_i = 1'b1;      // after k+1, rose_o high
    @(negedge clk) clr_i = 1'b0;      // after k+2
    vectors++;
    if (rise_cnt !== CNT_W'(1) || fall_cnt !== '0) begin
      $display("FAIL clear_coincident: got rc=%0d fc=%0d, expected 1/0", rise_cnt, fall_cnt);
      errors++;
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk) sig_in = 1'b0;
    repeat (3) @(negedge clk);
    sig_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (rose_o !== 1'b1) begin
      $display("FAIL pre_reset_rose: got %b, expected 1", rose_o);
      errors++;
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (rose_o !== 1'b0 || changed_o !== 1'b0 || rise_cnt !== '0 || fall_cnt !== '0 ||
        run_len !== '0 || viol_o !== 1'b0) begin
      $display("FAIL async_reset: got rose=%b chg=%b rc=%0d fc=%0d rl=%0d v=%b, expected all 0",
               rose_o, changed_o, rise_cnt, fall_cnt, run_len, viol_o);
      errors++;
    end
    @(negedge clk) rst_n = 1'b1;      // sig_in still 1
    @(negedge clk);
    vectors++;
    if (rose_o !== 1'b0) begin
      $display("FAIL post_reset_early: got rose=%b, expected 0", rose_o);
      errors++;
    end
    @(negedge clk);
    vectors++;
    if (rose_o !== 1'b1) begin
      $display("FAIL post_reset_rose: got rose=%b, expected 1", rose_o);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_pattern();
    test_glitch();
    test_enable();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
